// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one single-port synchronous SRAM
// between an instruction-fetch port and a load/store data port.
module mem_arb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;
  state_t r_state, w_state_nx;
  logic r_own_d, r_last_d, r_store, r_i_ack, r_d_ack, r_m_en, r_m_we;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata, r_m_wdata;
  logic [ADDR_W-1:0] r_m_addr;
  logic w_el_i, w_el_d, w_grant, w_pick_d;
  // A port being acked this cycle sees its next request only one cycle later
  assign w_el_i = i_req & ~r_i_ack;
  assign w_el_d = d_req & ~r_d_ack;
  assign w_grant = (r_state == IDLE) & (w_el_i | w_el_d);
  assign w_pick_d = w_el_d & (~w_el_i | ~r_last_d);
  always_comb begin
    w_state_nx = (r_state == IDLE) ? (w_grant ? ISSUE : IDLE) : (r_state == ISSUE) ? CAPT : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own_d   <= 1'b0;
      r_last_d  <= 1'b0;
      r_store   <= 1'b0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_m_en    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_m_en  <= w_grant;
      r_m_we  <= w_grant & w_pick_d & d_we;
      r_i_ack <= (r_state == CAPT) & ~r_own_d;
      r_d_ack <= (r_state == CAPT) & r_own_d;
      if (w_grant) begin
        r_own_d   <= w_pick_d;
        r_store   <= w_pick_d & d_we;
        r_m_addr  <= w_pick_d ? d_addr : i_addr;
        r_m_wdata <= w_pick_d ? d_wdata : '0;
      end
      if (r_state == CAPT) begin
        r_last_d <= r_own_d;
        if (!r_own_d) r_i_rdata <= m_rdata;
        if (r_own_d && !r_store) r_d_rdata <= m_rdata;
      end
    end
  end
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign i_ack   = r_i_ack;
  assign d_ack   = r_d_ack;
  assign m_en    = r_m_en;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
endmodule
